// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the writeback stage
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/riscv_load_align.sv
// rtl/riscv_load_align.sv - selects, aligns and extends load data from a raw memory word
module riscv_load_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lsb,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    import riscv_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the byte/halfword lane; halfword ignores addr_lsb[0] since misalignment traps earlier
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lsb)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend by load type; unknown encodings fall back to a full word
    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/riscv_wb_stage.sv
// rtl/riscv_wb_stage.sv - MEM->WB writeback stage; WB_INSTRET_EN adds a retired-instruction counter
module riscv_wb_stage #(
    parameter int XLEN = 32
`ifdef WB_INSTRET_EN
    ,
    parameter int INSTRET_W = 64
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic            mem_rd_write_i,
    input  logic [4:0]      mem_rd_addr_i,
    input  logic [XLEN-1:0] mem_alu_result_i,
    input  logic            mem_is_load_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_q_is_rd_write,
    output logic [4:0]      wb_rd_addr,
    output logic [XLEN-1:0] wb_rd_wdata
`ifdef WB_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0] wb_instret_o
`endif
);
    import riscv_pkg::*;

    wb_state_e       state;
    logic [4:0]      ld_rd;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_lsb;
    logic            ld_rd_write;
    logic [XLEN-1:0] ld_data;

    logic accept;
    logic accept_alu;
    logic load_done;
    logic retire;

    assign mem_ready_o = (state == WB_IDLE);
    assign accept      = mem_ready_o && mem_valid_i;
    assign accept_alu  = accept && !mem_is_load_i;
    assign load_done   = (state == WB_WAIT_LOAD) && dmem_rvalid_i;
    assign retire      = accept_alu || load_done;

    riscv_load_align u_align (
        .funct3   (ld_funct3),
        .addr_lsb (ld_lsb),
        .rdata    (dmem_rdata_i),
        .data     (ld_data)
    );

    // FSM and latched load context; rvalid is only honoured in WAIT_LOAD
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= WB_IDLE;
            ld_rd       <= 5'd0;
            ld_funct3   <= 3'd0;
            ld_lsb      <= 2'd0;
            ld_rd_write <= 1'b0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (accept && mem_is_load_i) begin
                        state       <= WB_WAIT_LOAD;
                        ld_rd       <= mem_rd_addr_i;
                        ld_funct3   <= mem_funct3_i;
                        ld_lsb      <= mem_alu_result_i[1:0];
                        ld_rd_write <= mem_rd_write_i;
                    end
                end
                WB_WAIT_LOAD: begin
                    if (dmem_rvalid_i) begin
                        state <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    // Registered write port; address/data only move when a write is actually strobed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_q_is_rd_write <= 1'b0;
            wb_rd_addr       <= 5'd0;
            wb_rd_wdata      <= '0;
        end else begin
            wb_q_is_rd_write <= 1'b0;
            if (accept_alu && mem_rd_write_i && (mem_rd_addr_i != 5'd0)) begin
                wb_q_is_rd_write <= 1'b1;
                wb_rd_addr       <= mem_rd_addr_i;
                wb_rd_wdata      <= mem_alu_result_i;
            end else if (load_done && ld_rd_write && (ld_rd != 5'd0)) begin
                wb_q_is_rd_write <= 1'b1;
                wb_rd_addr       <= ld_rd;
                wb_rd_wdata      <= ld_data;
            end
        end
    end

`ifdef WB_INSTRET_EN
    // Count every retirement, including those whose rd write is suppressed; wraps naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_instret_o <= '0;
        end else if (retire) begin
            wb_instret_o <= wb_instret_o + 1'b1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_riscv_wb_stage.sv
// tb/tb_riscv_wb_stage.sv - directed vector bench for riscv_wb_stage (WB_INSTRET_EN optional)
module tb_riscv_wb_stage;

    localparam int TB_INSTRET_W = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic        mem_rd_write_i;
    logic [4:0]  mem_rd_addr_i;
    logic [31:0] mem_alu_result_i;
    logic        mem_is_load_i;
    logic [2:0]  mem_funct3_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_q_is_rd_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_wdata;
`ifdef WB_INSTRET_EN
    logic [TB_INSTRET_W-1:0] wb_instret_o;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    logic [4:0]  last_addr;
    logic [31:0] last_wdata;
    int          exp_ret;

    always #5 clk_i = ~clk_i;

`ifdef WB_INSTRET_EN
    riscv_wb_stage #(.XLEN(32), .INSTRET_W(TB_INSTRET_W)) dut (
`else
    riscv_wb_stage #(.XLEN(32)) dut (
`endif
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .mem_valid_i      (mem_valid_i),
        .mem_ready_o      (mem_ready_o),
        .mem_rd_write_i   (mem_rd_write_i),
        .mem_rd_addr_i    (mem_rd_addr_i),
        .mem_alu_result_i (mem_alu_result_i),
        .mem_is_load_i    (mem_is_load_i),
        .mem_funct3_i     (mem_funct3_i),
        .dmem_rvalid_i    (dmem_rvalid_i),
        .dmem_rdata_i     (dmem_rdata_i),
        .wb_q_is_rd_write (wb_q_is_rd_write),
        .wb_rd_addr       (wb_rd_addr),
        .wb_rd_wdata      (wb_rd_wdata)
`ifdef WB_INSTRET_EN
        ,
        .wb_instret_o     (wb_instret_o)
`endif
    );

    typedef struct {
        string       name;
        logic        is_load;
        logic        rd_write;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          delay;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_port(input string name, input logic exp_we);
        check({name, "/we"}, {31'b0, wb_q_is_rd_write}, {31'b0, exp_we});
        check({name, "/addr"}, {27'b0, wb_rd_addr}, {27'b0, last_addr});
        check({name, "/wdata"}, wb_rd_wdata, last_wdata);
    endtask

    task automatic check_ret(input string name);
`ifdef WB_INSTRET_EN
        check({name, "/instret"}, {28'b0, wb_instret_o}, exp_ret[31:0] & 32'hF);
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic idle_inputs();
        mem_valid_i      = 1'b0;
        mem_rd_write_i   = 1'b0;
        mem_rd_addr_i    = 5'd0;
        mem_alu_result_i = 32'h0;
        mem_is_load_i    = 1'b0;
        mem_funct3_i     = 3'd0;
        dmem_rvalid_i    = 1'b0;
        dmem_rdata_i     = 32'h0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle_inputs();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        last_addr  = 5'd0;
        last_wdata = 32'h0;
        exp_ret    = 0;
    endtask

    task automatic apply(input vec_t v);
        mem_valid_i      = 1'b1;
        mem_is_load_i    = v.is_load;
        mem_rd_write_i   = v.rd_write;
        mem_rd_addr_i    = v.rd;
        mem_alu_result_i = v.alu;
        mem_funct3_i     = v.f3;
        check({v.name, "/ready_in"}, {31'b0, mem_ready_o}, 32'd1);
        @(negedge clk_i);
        idle_inputs();
        if (v.is_load) begin
            for (int i = 0; i < v.delay; i++) begin
                check({v.name, "/ready_wait"}, {31'b0, mem_ready_o}, 32'd0);
                check({v.name, "/we_wait"}, {31'b0, wb_q_is_rd_write}, 32'd0);
                @(negedge clk_i);
            end
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = v.rdata;
            @(negedge clk_i);
            idle_inputs();
        end
        exp_ret++;
        if (v.exp_we) begin
            last_addr  = v.rd;
            last_wdata = v.exp_wdata;
        end
        check_port(v.name, v.exp_we);
        check({v.name, "/ready_out"}, {31'b0, mem_ready_o}, 32'd1);
        check_ret(v.name);
        @(negedge clk_i);
        check({v.name, "/strobe_1cyc"}, {31'b0, wb_q_is_rd_write}, 32'd0);
    endtask

    initial begin
        //          name     load wr  rd     alu           f3      rdata        dly we  wdata
        vecs[0]  = '{"alu_rd5",   0, 1, 5'd5,  32'h1234_5678, 3'd0, 32'h0,         0, 1, 32'h1234_5678};
        vecs[1]  = '{"alu_rd0",   0, 1, 5'd0,  32'hDEAD_BEEF, 3'd0, 32'h0,         0, 0, 32'h0};
        vecs[2]  = '{"alu_rd7",   0, 1, 5'd7,  32'hCAFE_F00D, 3'd0, 32'h0,         0, 1, 32'hCAFE_F00D};
        vecs[3]  = '{"alu_nowr",  0, 0, 5'd9,  32'h5555_AAAA, 3'd0, 32'h0,         0, 0, 32'h0};
        vecs[4]  = '{"lb_a3",     1, 1, 5'd10, 32'h0000_1003, 3'b000, 32'h80FF_0000, 3, 1, 32'hFFFF_FF80};
        vecs[5]  = '{"lhu_a2",    1, 1, 5'd11, 32'h0000_2002, 3'b101, 32'h8001_0000, 1, 1, 32'h0000_8001};
        vecs[6]  = '{"lh_a2",     1, 1, 5'd12, 32'h0000_2002, 3'b001, 32'h8001_0000, 0, 1, 32'hFFFF_8001};
        vecs[7]  = '{"lbu_a1",    1, 1, 5'd13, 32'h0000_0001, 3'b100, 32'h0000_A500, 2, 1, 32'h0000_00A5};
        vecs[8]  = '{"lw",        1, 1, 5'd14, 32'h0000_0100, 3'b010, 32'h1357_9BDF, 0, 1, 32'h1357_9BDF};
        vecs[9]  = '{"lb_pos",    1, 1, 5'd15, 32'h0000_0000, 3'b000, 32'hFFFF_FF7F, 0, 1, 32'h0000_007F};
        vecs[10] = '{"f3_011",    1, 1, 5'd16, 32'h0000_0001, 3'b011, 32'h89AB_CDEF, 1, 1, 32'h89AB_CDEF};
        vecs[11] = '{"lh_a0",     1, 1, 5'd17, 32'h0000_0000, 3'b001, 32'h1234_F00F, 0, 1, 32'hFFFF_F00F};
        vecs[12] = '{"lhu_a3",    1, 1, 5'd18, 32'h0000_0003, 3'b101, 32'hBEEF_0000, 0, 1, 32'h0000_BEEF};
        vecs[13] = '{"ld_rd0",    1, 1, 5'd0,  32'h0000_0000, 3'b010, 32'h7777_7777, 1, 0, 32'h0};
        vecs[14] = '{"lb_a2",     1, 1, 5'd19, 32'h0000_0002, 3'b000, 32'hAA7F_5555, 0, 1, 32'h0000_007F};

        do_reset();
        check_port("reset", 1'b0);
        check("reset/ready", {31'b0, mem_ready_o}, 32'd1);
        check_ret("reset");

        // Reset while a load is outstanding, then a stray rvalid
        mem_valid_i      = 1'b1;
        mem_is_load_i    = 1'b1;
        mem_rd_write_i   = 1'b1;
        mem_rd_addr_i    = 5'd3;
        mem_alu_result_i = 32'h0;
        mem_funct3_i     = 3'b010;
        @(negedge clk_i);
        idle_inputs();
        check("rstload/ready_wait", {31'b0, mem_ready_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rstload/ready", {31'b0, mem_ready_o}, 32'd1);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1111_1111;
        @(negedge clk_i);
        idle_inputs();
        check_port("rstload", 1'b0);
        check("rstload/ready2", {31'b0, mem_ready_o}, 32'd1);
        check_ret("rstload");

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i]);
        end

        // Back-to-back non-loads: rd=0 then rd=7
        mem_valid_i      = 1'b1;
        mem_rd_write_i   = 1'b1;
        mem_rd_addr_i    = 5'd0;
        mem_alu_result_i = 32'h0BAD_0000;
        @(negedge clk_i);
        check("b2b/we0", {31'b0, wb_q_is_rd_write}, 32'd0);
        check("b2b/ready", {31'b0, mem_ready_o}, 32'd1);
        mem_rd_addr_i    = 5'd7;
        mem_alu_result_i = 32'h0000_0777;
        @(negedge clk_i);
        idle_inputs();
        exp_ret    += 2;
        last_addr  = 5'd7;
        last_wdata = 32'h0000_0777;
        check_port("b2b", 1'b1);
        check_ret("b2b");

        // rvalid in IDLE alongside a non-load accept
        mem_valid_i      = 1'b1;
        mem_rd_write_i   = 1'b1;
        mem_rd_addr_i    = 5'd12;
        mem_alu_result_i = 32'h0BAD_CAFE;
        dmem_rvalid_i    = 1'b1;
        dmem_rdata_i     = 32'hFFFF_FFFF;
        @(negedge clk_i);
        idle_inputs();
        exp_ret++;
        last_addr  = 5'd12;
        last_wdata = 32'h0BAD_CAFE;
        check_port("idle_rvalid", 1'b1);
        check("idle_rvalid/ready", {31'b0, mem_ready_o}, 32'd1);
        check_ret("idle_rvalid");
        @(negedge clk_i);
        check("idle_rvalid/after", {31'b0, wb_q_is_rd_write}, 32'd0);

        // 17 retirements from reset wrap a 4-bit counter to 1
        do_reset();
        mem_valid_i    = 1'b1;
        mem_rd_write_i = 1'b0;
        mem_rd_addr_i  = 5'd1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_i);
        end
        idle_inputs();
        exp_ret = 17;
        check_ret("wrap");
        check("wrap/we", {31'b0, wb_q_is_rd_write}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
